// File: rtl/gps_ack_peak_if.sv
// gps_ack_peak_if: per-lane result beat stream from the peak tracker to the acquisition controller
interface gps_ack_peak_if;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_lane;
    logic [5:0]  res_sat;
    logic [11:0] res_peak;
    logic [9:0]  res_phase;
    logic [11:0] res_second;
    logic        res_detect;
    logic        res_err;

    modport master (
        output res_valid,
        output res_lane,
        output res_sat,
        output res_peak,
        output res_phase,
        output res_second,
        output res_detect,
        output res_err,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_lane,
        input  res_sat,
        input  res_peak,
        input  res_phase,
        input  res_second,
        input  res_detect,
        input  res_err,
        output res_ready
    );
endinterface

// File: rtl/gps_ack_peak.sv
// gps_ack_peak: tracks per-lane peak and runner-up over a code-phase sweep and reports them lane by lane
module gps_ack_peak #(
    parameter int NUM_PHASES  = 1023,
    parameter int RATIO_SHIFT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           corr_complete,
    input  logic [9:0]     code_phase,
    input  logic [5:0]     sat0,
    input  logic [5:0]     sat1,
    input  logic [5:0]     sat2,
    input  logic [5:0]     sat3,
    input  logic [11:0]    integrator_0,
    input  logic [11:0]    integrator_1,
    input  logic [11:0]    integrator_2,
    input  logic [11:0]    integrator_3,
    gps_ack_peak_if.master res,
    output logic           busy,
    output logic           overrun
);
    localparam logic [9:0] LAST_PH = 10'(NUM_PHASES - 1);

    typedef enum logic [1:0] {IDLE, SNAP, REPORT} state_t;

    state_t      state;
    state_t      state_n;
    logic [5:0]  sat_in [4];
    logic [11:0] mag_in [4];
    logic [11:0] best [4];
    logic [11:0] second [4];
    logic [9:0]  best_ph [4];
    logic [5:0]  sat [4];
    logic [3:0]  err;
    logic [3:0]  det;
    logic        active;
    logic        end_pend;
    logic [9:0]  exp_ph;
    logic [11:0] s_best [4];
    logic [11:0] s_second [4];
    logic [9:0]  s_ph [4];
    logic [5:0]  s_sat [4];
    logic [3:0]  s_det;
    logic [3:0]  s_err;
    logic [1:0]  idx;
    logic        start;
    logic        step;
    logic        last;
    logic        hs;
    logic        valid;

    assign sat_in[0] = sat0;
    assign sat_in[1] = sat1;
    assign sat_in[2] = sat2;
    assign sat_in[3] = sat3;
    assign mag_in[0] = integrator_0;
    assign mag_in[1] = integrator_1;
    assign mag_in[2] = integrator_2;
    assign mag_in[3] = integrator_3;

    assign start = corr_complete && code_phase == '0;
    assign step  = corr_complete && code_phase != '0 && active;
    assign last  = step && code_phase == LAST_PH;
    assign valid = state == REPORT;
    assign hs    = valid && res.res_ready;

    // sweep tracking: phase 0 opens a sweep, the final phase closes it, every step resyncs the expected phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            exp_ph <= '0;
        end else if (start) begin
            active <= 1'b1;
            exp_ph <= 10'd1;
        end else if (step) begin
            exp_ph <= code_phase + 10'd1;
            if (last) active <= 1'b0;
        end
    end

    // lane accumulators: keep best/second with strict compares so the earliest phase wins ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best    <= '{default: '0};
            second  <= '{default: '0};
            best_ph <= '{default: '0};
            sat     <= '{default: '0};
            err     <= '0;
        end else if (start) begin
            for (int i = 0; i < 4; i++) begin
                sat[i]     <= sat_in[i];
                best[i]    <= mag_in[i];
                best_ph[i] <= '0;
                second[i]  <= '0;
                err[i]     <= active;
            end
        end else if (step) begin
            for (int i = 0; i < 4; i++) begin
                if (code_phase != exp_ph) err[i] <= 1'b1;
                if (mag_in[i] > best[i]) begin
                    second[i]  <= best[i];
                    best[i]    <= mag_in[i];
                    best_ph[i] <= code_phase;
                end else if (mag_in[i] > second[i]) begin
                    second[i] <= mag_in[i];
                end
            end
        end
    end

    // ratio test in 13 bits so second plus its scaled copy cannot wrap
    always_comb begin
        det = '0;
        for (int i = 0; i < 4; i++)
            det[i] = {1'b0, best[i]} > ({1'b0, second[i]} + 13'(second[i] >> RATIO_SHIFT));
    end

    // sweep-end handoff: a sweep ending while a report is in flight is dropped and flagged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            end_pend <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (valid && end_pend) overrun <= 1'b1;
            end_pend <= last ? 1'b1 : (state != IDLE ? 1'b0 : end_pend);
        end
    end

    // report FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // report FSM next state: one snapshot cycle, then four lane beats
    always_comb begin
        state_n = state;
        if (state == IDLE && end_pend)  state_n = SNAP;
        else if (state == SNAP)         state_n = REPORT;
        else if (hs && idx == 2'd3)     state_n = IDLE;
    end

    // snapshot capture and beat index; lane registers keep accumulating underneath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_best   <= '{default: '0};
            s_second <= '{default: '0};
            s_ph     <= '{default: '0};
            s_sat    <= '{default: '0};
            s_det    <= '0;
            s_err    <= '0;
            idx      <= '0;
        end else if (state == SNAP) begin
            s_best   <= best;
            s_second <= second;
            s_ph     <= best_ph;
            s_sat    <= sat;
            s_det    <= det;
            s_err    <= err;
            idx      <= '0;
        end else if (hs) begin
            idx <= idx + 2'd1;
        end
    end

    assign res.res_valid  = valid;
    assign res.res_lane   = valid ? idx : '0;
    assign res.res_sat    = valid ? s_sat[idx] : '0;
    assign res.res_peak   = valid ? s_best[idx] : '0;
    assign res.res_phase  = valid ? s_ph[idx] : '0;
    assign res.res_second = valid ? s_second[idx] : '0;
    assign res.res_detect = valid && s_det[idx];
    assign res.res_err    = valid && s_err[idx];
    assign busy           = state != IDLE;
endmodule

// File: tb/tb_gps_ack_peak.sv
// tb_gps_ack_peak: randomized sweeps checked against a sort-based reference of each sweep's samples
module tb_gps_ack_peak;
    localparam int NP = 1023;

    typedef struct {
        int lane;
        int sat;
        int peak;
        int ph;
        int sec;
        int det;
        int err;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        corr_complete = 1'b0;
    logic [9:0]  code_phase = '0;
    logic [5:0]  sat_d [4];
    logic [11:0] mag_d [4];
    logic        busy;
    logic        overrun;

    gps_ack_peak_if res ();

    gps_ack_peak dut (
        .clk           (clk),
        .rst           (rst),
        .corr_complete (corr_complete),
        .code_phase    (code_phase),
        .sat0          (sat_d[0]),
        .sat1          (sat_d[1]),
        .sat2          (sat_d[2]),
        .sat3          (sat_d[3]),
        .integrator_0  (mag_d[0]),
        .integrator_1  (mag_d[1]),
        .integrator_2  (mag_d[2]),
        .integrator_3  (mag_d[3]),
        .res           (res),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    beat_t exp_q [$];
    int    q_val [4][$];
    int    q_ph [$];
    int    m_sat [4];
    bit    m_active = 1'b0;
    bit    m_err = 1'b0;
    int    m_prev = 0;
    int    spike_ph [4];
    int    spike_amp [4];
    int    n_run = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int gen(input int mode, input int l, input int ph);
        if (mode == 0) return l == 0 ? (ph == 517 ? 100 : ph == 9 ? 40 : 10) : int'($urandom_range(0, 200));
        if (mode == 1) return 50;
        if (mode == 2) return ph == spike_ph[l] ? spike_amp[l] : int'($urandom_range(0, 400));
        return int'($urandom_range(0, 7));
    endfunction

    // top two of the sample multiset; earliest phase holding the maximum
    task automatic close_sweep();
        int    s [$];
        beat_t b;
        for (int l = 0; l < 4; l++) begin
            s = q_val[l];
            s.rsort();
            b.lane = l;
            b.sat  = m_sat[l];
            b.peak = s[0];
            b.sec  = s.size() > 1 ? s[1] : 0;
            b.ph   = 0;
            for (int k = 0; k < q_ph.size(); k++)
                if (q_val[l][k] == b.peak) begin
                    b.ph = q_ph[k];
                    break;
                end
            b.det = b.peak > b.sec + (b.sec >> 1) ? 1 : 0;
            b.err = m_err ? 1 : 0;
            exp_q.push_back(b);
        end
    endtask

    task automatic strobe(input int ph, input int mode);
        @(negedge clk);
        corr_complete = 1'b1;
        code_phase    = 10'(ph);
        for (int l = 0; l < 4; l++) begin
            mag_d[l] = 12'(gen(mode, l, ph));
            sat_d[l] = 6'($urandom_range(0, 63));
        end
        if (ph == 0) begin
            m_err    = m_active;
            m_active = 1'b1;
            m_prev   = 0;
            q_ph.delete();
            for (int l = 0; l < 4; l++) begin
                q_val[l].delete();
                m_sat[l] = sat_d[l];
            end
        end else if (m_active) begin
            if (ph != m_prev + 1) m_err = 1'b1;
            m_prev = ph;
        end
        if (m_active) begin
            q_ph.push_back(ph);
            for (int l = 0; l < 4; l++) q_val[l].push_back(int'(mag_d[l]));
            if (ph == NP - 1) begin
                m_active = 1'b0;
                close_sweep();
            end
        end
    endtask

    task automatic sweep(input int mode, input int skip, input int stop_at);
        for (int l = 0; l < 4; l++) begin
            spike_ph[l]  = $urandom_range(0, NP - 1);
            spike_amp[l] = $urandom_range(0, 4095);
        end
        for (int ph = 0; ph < NP; ph++) begin
            if (ph == skip) continue;
            strobe(ph, mode);
            if (ph == stop_at) break;
        end
        @(negedge clk);
        corr_complete = 1'b0;
    endtask

    task automatic cmp(input beat_t e);
        check("lane", res.res_lane, e.lane);
        check("sat", res.res_sat, e.sat);
        check("peak", res.res_peak, e.peak);
        check("phase", res.res_phase, e.ph);
        check("second", res.res_second, e.sec);
        check("detect", res.res_detect, e.det);
        check("err", res.res_err, e.err);
    endtask

    task automatic take(input int n, input int stall_lane, input int stall_cyc);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            int t = 0;
            while (!res.res_valid && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!res.res_valid) begin
                check("beat_timeout", 0, 1);
                res.res_ready = 1'b0;
                return;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
                res.res_ready = 1'b0;
                return;
            end
            e = exp_q.pop_front();
            cmp(e);
            if (e.lane == stall_lane) begin
                res.res_ready = 1'b0;
                for (int c = 0; c < stall_cyc; c++) begin
                    @(negedge clk);
                    check("hold_valid", res.res_valid, 1);
                    check("hold_lane", res.res_lane, e.lane);
                    check("hold_peak", res.res_peak, e.peak);
                    check("hold_second", res.res_second, e.sec);
                end
            end
            res.res_ready = 1'b1;
            @(negedge clk);
        end
        res.res_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, res.res_valid, 0);
        check({tag, "_lane"}, res.res_lane, 0);
        check({tag, "_sat"}, res.res_sat, 0);
        check({tag, "_peak"}, res.res_peak, 0);
        check({tag, "_phase"}, res.res_phase, 0);
        check({tag, "_second"}, res.res_second, 0);
        check({tag, "_detect"}, res.res_detect, 0);
        check({tag, "_err"}, res.res_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic quiet(input string tag, input int cyc);
        int seen = 0;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            if (res.res_valid) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        res.res_ready = 1'b0;
        for (int l = 0; l < 4; l++) begin
            sat_d[l] = '0;
            mag_d[l] = '0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        // phase 5 with no open sweep is ignored
        repeat (3) strobe(5, 2);
        @(negedge clk);
        corr_complete = 1'b0;
        quiet("stray_phase", 10);
        check("stray_busy", busy, 0);
        // directed clean sweep plus latency and minimum report time
        sweep(0, -1, -1);
        check("lat_n1_valid", res.res_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", res.res_valid, 0);
        check("lat_n2_busy", busy, 1);
        @(negedge clk);
        check("lat_n3_valid", res.res_valid, 1);
        take(4, -1, 0);
        check("busy_after", busy, 0);
        sweep(1, -1, -1);
        take(4, -1, 0);
        sweep(2, 300, -1);
        take(4, -1, 0);
        sweep(3, -1, -1);
        take(4, 2, 5);
        // second sweep ends while lane 1 of the first is stalled
        sweep(2, -1, -1);
        fork
            take(4, 1, 1060);
            sweep(2, -1, -1);
        join
        repeat (4) void'(exp_q.pop_back());
        quiet("dropped_snapshot", 10);
        check("overrun", overrun, 1);
        // restart at phase 600 then a full sweep
        sweep(2, -1, 600);
        sweep(2, -1, -1);
        take(4, -1, 0);
        repeat (2) begin
            sweep(2, -1, -1);
            take(4, $urandom_range(0, 3), $urandom_range(0, 6));
        end
        // reset in the middle of the report
        sweep(2, -1, -1);
        take(2, -1, 0);
        for (int t = 0; t < 20 && !res.res_valid; t++) @(negedge clk);
        check("pre_rst_lane", res.res_lane, 2);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        exp_q.delete();
        m_active = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int ph = 1; ph < 60; ph++) strobe(ph, 2);
        @(negedge clk);
        corr_complete = 1'b0;
        quiet("post_rst", 20);
        sweep(2, -1, -1);
        take(4, -1, 0);
        check("leftover_beats", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
